umstr_udp_tx_sched: RTL
=======================

// Module: umstr_udp_tx_sched
// PURPOSE
//  Packet-level weighted round-robin scheduler for the UDP transmit mux. Watches each source's
//  tvld/tlast and the mux's accepted-beat strobe, and emits a registered one-hot grant naming
//  which source owns the mux. Grants switch only at packet boundaries. A mid-packet source
//  stall is aborted by a watchdog. Per-source packet counters feed status registers.
// PARAMETERS
//  NUM_SRC    3     number of requesting streams (>=2); index 0 = highest tie priority
//  WEIGHT_W   4     width of each per-source weight (packets per turn)
//  TMO_CYC    1024  mid-packet source-idle cycles before abort (>=2)
//  CNT_W      16    width of each per-source packet counter
// PORTS
//  clk          in   1                 system clock
//  reset_n      in   1                 async active-low reset
//  src_tvld_i   in   NUM_SRC           tvld of each source stream
//  src_tlast_i  in   NUM_SRC           tlast of each source stream
//  weight_i     in   NUM_SRC*WEIGHT_W  packets per turn; src k at [k*WEIGHT_W +: WEIGHT_W]; 0 means 1
//  beat_acc_i   in   1                 mux accepted one beat from the granted source (tvld&trdy)
//  grant_o      out  NUM_SRC           one-hot grant; all zero = none
//  grant_vld_o  out  1                 grant_o nonzero
//  grant_id_o   out  $clog2(NUM_SRC)   binary index of granted source
//  sop_o        out  1                 next accepted beat is the first beat of a packet
//  abort_o      out  1                 1-cycle pulse: watchdog revoked grant mid-packet
//  pkt_cnt_o    out  NUM_SRC*CNT_W     completed packets per source; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: async, active-low. All outputs 0. State=IDLE, rr pointer=0, credits=0, counters=0.
//   A reset mid-packet drops the grant immediately. No packet state is retained.
//  FSM states:
//   IDLE: if any src_tvld_i, pick the winner, register grant, go to GRANT. Else stay.
//   GRANT: hold grant_o. in_pkt sets on beat_acc_i & ~tlast. It clears on beat_acc_i & tlast.
//   SWITCH: one dead cycle, grant_o=0. Pick the winner. Go to GRANT, or to IDLE if no tvld.
//  Winner = first k with src_tvld_i[k], searching from rr_ptr upward with modulo NUM_SRC wrap.
//   On a grant: rr_ptr <= winner+1 (wraps). The winner's credit loads weight (0 -> 1).
//  Packet end = beat_acc_i & src_tlast_i[grant_id] & state==GRANT.
//   On packet end: credit-1, pkt_cnt[grant_id]+1.
//  At a boundary (GRANT & ~in_pkt): go to SWITCH if credit==0.
//   Also go to SWITCH if the granted source's tvld is low while another source's tvld is high.
//   Otherwise keep the grant, including an idle hold when no other source is requesting.
//  Latency: tvld in IDLE -> grant_o high on the next edge (1 cycle).
//   Packet end with exhausted credit -> grant_o=0 for 1 cycle (SWITCH) -> new grant.
//  sop_o = grant_vld_o & ~in_pkt (combinational from registers).
//  Watchdog: counts cycles in GRANT & in_pkt & ~src_tvld_i[grant_id]. Any beat_acc_i clears it.
//   Sink backpressure never counts: cycles with the source's tvld high are not counted.
//   At count==TMO_CYC-1: abort_o pulses, in_pkt clears, credit clears, go to SWITCH.
//   pkt_cnt does not increment on an abort.
//  Simultaneous events: packet end and watchdog expiry in the same cycle -> packet end wins,
//   no abort. beat_acc_i outside GRANT is ignored. Tvld inputs are sampled only at boundaries
//   and in IDLE/SWITCH; a tvld drop mid-packet only feeds the watchdog.
//  Counter wrap: 2^CNT_W-1 +1 -> 0, no saturation or flag.
//  The grant never changes while in_pkt=1, except on abort or reset.
// TESTING
//  1) Reset, src0..2 tvld=1, weights 1/1/1, 1-beat packets, beat_acc every grant cycle
//     -> grant order 0,1,2,0,... with 1 dead SWITCH cycle between grants.
//  2) weights 3/1/1, all requesting, 2-beat packets -> src0 sends 3 packets, then src1 1, then
//     src2 1, and so on; pkt_cnt after 10 packets = 6/2/2.
//  3) Only src1 requests, weight 2 -> grant held across packets with no SWITCH cycles; src2 then
//     requests at a boundary after credit expiry -> grant moves to src2.
//  4) Mid-packet, granted src tvld=0 for TMO_CYC=16 cycles -> abort_o pulse at cycle 16, grant=0
//     the next cycle, pkt_cnt unchanged; beat_acc_i=0 with tvld=1 for 100 cycles -> no abort.
//  5) Assert reset_n=0 mid-packet -> all outputs 0 asynchronously; after release with src2 only
//     requesting -> grant_id_o=2 after 1 cycle.
//  6) CNT_W=4, 17 packets from src0 -> pkt_cnt src0 = 1; weight 0 behaves as weight 1.

Source files
------------

// File: rtl/umstr_udp_tx_sched.sv
// umstr_udp_tx_sched: packet-level weighted round-robin grant
// for the UDP transmit mux, with mid-packet stall watchdog.
module umstr_udp_tx_sched #(
  parameter int NUM_SRC  = 3,
  parameter int WEIGHT_W = 4,
  parameter int TMO_CYC  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_SRC-1:0]          src_tvld_i,
  input  logic [NUM_SRC-1:0]          src_tlast_i,
  input  logic [NUM_SRC*WEIGHT_W-1:0] weight_i,
  input  logic                        beat_acc_i,
  output logic [NUM_SRC-1:0]          grant_o,
  output logic                        grant_vld_o,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id_o,
  output logic                        sop_o,
  output logic                        abort_o,
  output logic [NUM_SRC*CNT_W-1:0]    pkt_cnt_o
);

  localparam int ID_W = $clog2(NUM_SRC);
  localparam int WD_W = $clog2(TMO_CYC);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SWITCH
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                in_pkt_q, in_pkt_d;
  logic [WD_W-1:0]     wd_q;
  logic [CNT_W-1:0]    cnt_q [NUM_SRC];

  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     rr_nxt;
  logic [WEIGHT_W-1:0] wsel;
  logic [WEIGHT_W-1:0] wload;
  logic [WEIGHT_W-1:0] credit_dec;
  logic [WEIGHT_W-1:0] cred_nxt;
  logic                tvld_g;
  logic                tlast_g;
  logic                other_req;
  logic                pkt_end;
  logic                abort;
  logic                bnd;
  logic                take;

  assign tvld_g    = |(src_tvld_i & grant_q);
  assign tlast_g   = |(src_tlast_i & grant_q);
  assign other_req = |(src_tvld_i & ~grant_q);

  assign pkt_end = (state_q == GRANT) & beat_acc_i & tlast_g;

  // a beat accepted in the expiry cycle counts as progress
  assign abort = (state_q == GRANT) & in_pkt_q & ~tvld_g
               & ~beat_acc_i & ~pkt_end
               & (wd_q == WD_W'(TMO_CYC - 1));

  // credit saturates at zero while a lone source keeps the mux
  assign credit_dec = (credit_q == '0) ? '0 : credit_q - 1'b1;

  assign wload  = (wsel == '0) ? WEIGHT_W'(1) : wsel;
  assign rr_nxt = (win_id == ID_W'(NUM_SRC - 1)) ? '0
                : win_id + 1'b1;

  // round-robin winner search from rr pointer, plus its weight
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_id  = '0;
    wsel    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (src_tvld_i[j]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(j);
      end
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (win_id == ID_W'(k))
        wsel = weight_i[k*WEIGHT_W +: WEIGHT_W];
    end
  end

  // next-state and grant bookkeeping
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    rr_d     = rr_q;
    credit_d = credit_q;
    in_pkt_d = in_pkt_q;
    cred_nxt = credit_q;
    bnd      = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = win_vld;
      end
      GRANT: begin
        if (abort) begin
          state_d  = SWITCH;
          grant_d  = '0;
          gid_d    = '0;
          in_pkt_d = 1'b0;
          credit_d = '0;
        end else begin
          if (beat_acc_i) in_pkt_d = ~tlast_g;
          if (pkt_end)    credit_d = credit_dec;
          cred_nxt = pkt_end ? credit_dec : credit_q;
          bnd      = pkt_end | (~in_pkt_q & ~beat_acc_i);
          // hand over only when someone else is waiting
          if (bnd && other_req &&
              (cred_nxt == '0 || !tvld_g)) begin
            state_d = SWITCH;
            grant_d = '0;
            gid_d   = '0;
          end
        end
      end
      SWITCH: begin
        take = win_vld;
        if (!win_vld) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take) begin
      state_d  = GRANT;
      grant_d  = NUM_SRC'(1) << win_id;
      gid_d    = win_id;
      rr_d     = rr_nxt;
      credit_d = wload;
      in_pkt_d = 1'b0;
    end
  end

  // scheduler state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gid_q    <= '0;
      rr_q     <= '0;
      credit_q <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  // watchdog: counts source-idle cycles inside a packet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (state_q == GRANT && in_pkt_q && !abort) begin
      if (beat_acc_i)
        wd_q <= '0;
      else if (!tvld_g)
        wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  // completed-packet counters, free-running wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (pkt_end && grant_q[k])
          cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
    assign pkt_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign grant_o     = grant_q;
  assign grant_vld_o = |grant_q;
  assign grant_id_o  = gid_q;
  assign sop_o       = grant_vld_o & ~in_pkt_q;
  assign abort_o     = abort;

endmodule
